fft_shift_ctrl: RTL
===================

FFT_SHIFT_CTRL -- requirements
Module: fft_shift_ctrl

Interface
REQ-001 SHALL have parameter FFT_SIZE, default 8192, FFT frame length in bins.
REQ-002 SHALL have parameter SHIFT_SIZE, default 4000, half-width of the shifted output frame (output frame = 2*SHIFT_SIZE bins).
REQ-003 SHALL have parameter RESYNC_CYCLES, default 4, length of the downstream reset pulse.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-005 SHALL have ports: cfg_start in 1 (run request pulse); cfg_stop in 1 (stop-after-frame pulse); cfg_num_frames in 16 (frames to pass, 0 = continuous).
REQ-006 SHALL have ports: s_valid in 1; s_sof in 1; s_eof in 1; s_power in 32 (FFT power stream).
REQ-007 SHALL have ports: sh_rst out 1 (active-high shift-block reset); sh_valid out 1; sh_power out 32; sh_index out 13.
REQ-008 SHALL have ports: sh_valid_out in 1; o_sof out 1; o_eof out 1 (shifted-output framing markers).
REQ-009 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); err_frame out 1 (sticky); frames_in out 16.

Function
REQ-010 SHALL implement states IDLE, RESYNC, WAIT_SOF, RUN, ERROR.
REQ-011 IDLE: cfg_start -> RESYNC; clear err_frame, frames_in. All other inputs ignored.
REQ-012 RESYNC: sh_rst=1 for exactly RESYNC_CYCLES cycles, then -> WAIT_SOF; sh_valid=0 throughout.
REQ-013 WAIT_SOF: beats without s_sof are discarded; s_valid&s_sof -> RUN, and that beat is forwarded with sh_index=0.
REQ-014 RUN: every s_valid beat is forwarded; sh_index increments by 1 per forwarded beat, 0..FFT_SIZE-1.
REQ-015 Forwarding latency SHALL be 1 cycle: sh_valid/sh_power/sh_index registered from s_valid/s_power/bin counter.
REQ-016 Frame error in RUN: s_sof with bin count != 0, s_eof with bin count != FFT_SIZE-1, or missing s_eof at bin FFT_SIZE-1 -> offending beat not forwarded, err_frame=1, -> ERROR.
REQ-017 ERROR SHALL last one cycle, then -> RESYNC (shift block flushed of partial frame).
REQ-018 Good frame end (s_valid&s_eof at bin FFT_SIZE-1): frames_in+1 (saturating at 0xFFFF).
REQ-019 At good frame end: if cfg_stop pending, or cfg_num_frames!=0 and frames_in+1==cfg_num_frames -> IDLE with done=1 for one cycle; else -> WAIT_SOF.
REQ-020 cfg_stop SHALL be latched in any non-IDLE state; in WAIT_SOF or RESYNC it takes effect immediately (-> IDLE, done=1).
REQ-021 cfg_start outside IDLE SHALL be ignored.
REQ-022 busy=1 in every state except IDLE.
REQ-023 Output side: counter of sh_valid_out beats 0..2*SHIFT_SIZE-1, wraps to 0; o_sof=sh_valid_out at count 0; o_eof=sh_valid_out at count 2*SHIFT_SIZE-1; combinational from sh_valid_out.
REQ-024 Output counter SHALL clear whenever sh_rst=1.
REQ-025 Simultaneous s_sof and s_eof on one beat SHALL be a frame error in RUN and ignored as sof in WAIT_SOF.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, sh_rst=1, sh_valid=0, sh_power=0, sh_index=0, busy=0, done=0, err_frame=0, frames_in=0, output counter=0, stop latch=0.
REQ-027 After rst_n release, sh_rst SHALL deassert on the first clk edge (IDLE drives sh_rst=0).

Structure
REQ-028 FFT_SIZE, SHIFT_SIZE, index width (13) and state encoding SHALL live in shared package fft_shift_pkg.
REQ-029 The output framing counter SHALL be sub-module fft_out_framer; the FSM and input path stay in fft_shift_ctrl.

Verification
REQ-030 cfg_start, cfg_num_frames=2, two clean 8192-beat frames -> sh_rst high 4 cycles, sh_index 0..8191 twice, frames_in=2, done pulse 1 cycle after 2nd eof, busy=0.
REQ-031 s_sof at bin 100 in RUN -> beat not forwarded, err_frame=1, sh_rst 4 cycles, next good sof forwarded with sh_index=0.
REQ-032 Stream begins mid-frame (no sof for 500 beats) -> no sh_valid until first sof; first forwarded sh_index=0.
REQ-033 cfg_num_frames=0, cfg_stop at bin 3000 -> frame completes to bin 8191, then IDLE, done=1, frames_in incremented.
REQ-034 sh_valid_out held high 16000 cycles -> o_sof at beats 0 and 8000, o_eof at beats 7999 and 15999.
REQ-035 rst_n low at bin 4000 of a frame -> all outputs at reset values immediately; after release, cfg_start restarts cleanly with frames_in=0.

Source files
------------

// File: rtl/fft_shift_pkg.sv
// Shared constants, state encoding and helpers for the FFT shift controller.
package fft_shift_pkg;

  localparam int FFT_SIZE_DEF   = 8192;
  localparam int SHIFT_SIZE_DEF = 4000;
  localparam int IDX_W          = 13;
  localparam int FRAME_CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESYNC   = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_RUN      = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (v == {FRAME_CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fft_out_framer.sv
// Output-side framing: counts shifted beats per 2*SHIFT_SIZE frame and flags
// the first and last beat combinationally.
module fft_out_framer
  import fft_shift_pkg::*;
#(
  parameter int SHIFT_SIZE = SHIFT_SIZE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sh_rst,
  input  logic sh_valid_out,
  output logic o_sof,
  output logic o_eof
);

  localparam int FRAME_LEN = 2 * SHIFT_SIZE;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next beat position, cleared while the shift block is held in reset
  always_comb begin
    cnt_d = cnt_q;
    if (sh_rst) begin
      cnt_d = '0;
    end else if (sh_valid_out) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // beat counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_sof = sh_valid_out & (cnt_q == '0);
  assign o_eof = sh_valid_out & (cnt_q == LAST_CNT);

endmodule

// File: rtl/fft_shift_ctrl.sv
// FFT shift controller: frames the FFT power stream into the shift block,
// resynchronising the shift block after start-up and after any framing error.
module fft_shift_ctrl
  import fft_shift_pkg::*;
#(
  parameter int FFT_SIZE      = FFT_SIZE_DEF,
  parameter int SHIFT_SIZE    = SHIFT_SIZE_DEF,
  parameter int RESYNC_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [15:0]      cfg_num_frames,
  input  logic             s_valid,
  input  logic             s_sof,
  input  logic             s_eof,
  input  logic [31:0]      s_power,
  output logic             sh_rst,
  output logic             sh_valid,
  output logic [31:0]      sh_power,
  output logic [IDX_W-1:0] sh_index,
  input  logic             sh_valid_out,
  output logic             o_sof,
  output logic             o_eof,
  output logic             busy,
  output logic             done,
  output logic             err_frame,
  output logic [15:0]      frames_in
);

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_SIZE - 1);
  localparam int RS_W = $clog2(RESYNC_CYCLES) + 1;
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESYNC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bin_q, bin_d;
  logic [RS_W-1:0]  rs_cnt_q, rs_cnt_d;
  logic             stop_q, stop_d;
  logic             sh_rst_q, sh_rst_d;
  logic             sh_valid_q, sh_valid_d;
  logic [31:0]      sh_power_q, sh_power_d;
  logic [IDX_W-1:0] sh_index_q, sh_index_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      frames_q, frames_d;

  logic stop_req;
  logic last_bin;
  logic frame_bad;
  logic hit_count;

  // next state, forwarding decision and status updates
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    rs_cnt_d   = rs_cnt_q;
    stop_d     = stop_q;
    sh_valid_d = 1'b0;
    sh_power_d = sh_power_q;
    sh_index_d = sh_index_q;
    done_d     = 1'b0;
    err_d      = err_q;
    frames_d   = frames_q;
    stop_req   = stop_q | cfg_stop;
    last_bin   = (bin_q == LAST_BIN);
    // a sof is never legal mid-frame; eof must land exactly on the last bin
    frame_bad  = s_sof | (s_eof ^ last_bin);
    hit_count  = (cfg_num_frames != 16'd0) &&
                 (({1'b0, frames_q} + 17'd1) == {1'b0, cfg_num_frames});

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (cfg_start) begin
          state_d  = ST_RESYNC;
          rs_cnt_d = '0;
          err_d    = 1'b0;
          frames_d = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESYNC: begin
        if (stop_req) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end else if (rs_cnt_q == RS_LAST) begin
          state_d  = ST_WAIT_SOF;
          rs_cnt_d = '0;
        end else begin
          rs_cnt_d = rs_cnt_q + RS_W'(1'b1);
        end
      end
      ST_WAIT_SOF: begin
        bin_d = '0;
        if (stop_req) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          stop_d  = 1'b0;
        end else if (s_valid && s_sof && !s_eof) begin
          state_d    = ST_RUN;
          sh_valid_d = 1'b1;
          sh_power_d = s_power;
          sh_index_d = '0;
          bin_d      = IDX_W'(1'b1);
        end else begin
          state_d = ST_WAIT_SOF;
        end
      end
      ST_RUN: begin
        stop_d = stop_req;
        if (!s_valid) begin
          state_d = ST_RUN;
        end else if (frame_bad) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
          bin_d   = '0;
        end else begin
          sh_valid_d = 1'b1;
          sh_power_d = s_power;
          sh_index_d = bin_q;
          if (last_bin) begin
            frames_d = sat_inc(frames_q);
            bin_d    = '0;
            if (stop_req || hit_count) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
            end else begin
              state_d = ST_WAIT_SOF;
            end
          end else begin
            bin_d = bin_q + IDX_W'(1'b1);
          end
        end
      end
      ST_ERROR: begin
        stop_d   = stop_req;
        state_d  = ST_RESYNC;
        rs_cnt_d = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        bin_d    = '0;
        rs_cnt_d = '0;
        stop_d   = 1'b0;
      end
    endcase

    sh_rst_d = (state_d == ST_RESYNC);
    busy_d   = (state_d != ST_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      rs_cnt_q   <= '0;
      stop_q     <= 1'b0;
      sh_rst_q   <= 1'b1;
      sh_valid_q <= 1'b0;
      sh_power_q <= 32'd0;
      sh_index_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      frames_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      rs_cnt_q   <= rs_cnt_d;
      stop_q     <= stop_d;
      sh_rst_q   <= sh_rst_d;
      sh_valid_q <= sh_valid_d;
      sh_power_q <= sh_power_d;
      sh_index_q <= sh_index_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      frames_q   <= frames_d;
    end
  end

  assign sh_rst    = sh_rst_q;
  assign sh_valid  = sh_valid_q;
  assign sh_power  = sh_power_q;
  assign sh_index  = sh_index_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_frame = err_q;
  assign frames_in = frames_q;

  fft_out_framer #(
    .SHIFT_SIZE(SHIFT_SIZE)
  ) u_out_framer (
    .clk         (clk),
    .rst_n       (rst_n),
    .sh_rst      (sh_rst_q),
    .sh_valid_out(sh_valid_out),
    .o_sof       (o_sof),
    .o_eof       (o_eof)
  );

endmodule
